// File: rtl/fetch_decode_buffer_if.sv
// -----------------------------------------------------------------------------
// fetch_decode_buffer_if
// Bundles the Fetch-side inputs and Decode-side outputs of the Fetch/Decode
// pipeline register.
//
// Signals:
//   stall        Fetch -> buffer   hold all state this cycle
//   flush        Fetch -> buffer   discard buffered / in-flight instruction
//   in_inst[16]  Fetch -> buffer   instruction word
//   in_pc[32]    Fetch -> buffer   propagated PC
//   out_inst[16] buffer -> Decode  opcode word (NOP when out_valid=0)
//   out_imm[16]  buffer -> Decode  immediate word (0 for one-word instr.)
//   out_pc[32]   buffer -> Decode  PC associated with out_inst
//   out_valid    buffer -> Decode  packet holds a real instruction
//   out_two_word buffer -> Decode  packet carries a valid immediate
//   imm_wait     buffer -> Decode  first word held, awaiting its immediate
//
// Modports:
//   master  the side that feeds Fetch data in and consumes Decode data
//   slave   the pipeline register itself
// -----------------------------------------------------------------------------
interface fetch_decode_buffer_if;
    logic        stall;
    logic        flush;
    logic [15:0] in_inst;
    logic [31:0] in_pc;
    logic [15:0] out_inst;
    logic [15:0] out_imm;
    logic [31:0] out_pc;
    logic        out_valid;
    logic        out_two_word;
    logic        imm_wait;

    modport master (
        output stall, flush, in_inst, in_pc,
        input  out_inst, out_imm, out_pc, out_valid, out_two_word, imm_wait
    );

    modport slave (
        input  stall, flush, in_inst, in_pc,
        output out_inst, out_imm, out_pc, out_valid, out_two_word, imm_wait
    );
endinterface

// File: rtl/fetch_decode_buffer.sv
// -----------------------------------------------------------------------------
// fetch_decode_buffer
// Pipeline register between Fetch and Decode. One-word instructions pass
// through in one cycle. A word with bit IMM_BIT set is held while the next
// fetched word is captured as its immediate; the pair is then presented to
// Decode as a single packet, leaving exactly one bubble. Flush inserts a
// bubble and drops any held first word; stall freezes everything.
//
// Ports:
//   clk    system clock, all state changes on the rising edge
//   reset  synchronous active-high reset
//   bus    fetch_decode_buffer_if.slave (see interface header)
//
// Every output comes straight from a register: no input-to-output
// combinational path.
// -----------------------------------------------------------------------------
module fetch_decode_buffer #(
    parameter int          IMM_BIT  = 10,
    parameter logic [15:0] NOP_WORD = 16'h0000
) (
    input  logic                         clk,
    input  logic                         reset,
    fetch_decode_buffer_if.slave         bus
);

    typedef enum logic {
        FIRST    = 1'b0,
        WAIT_IMM = 1'b1
    } state_t;

    // Registered state.
    state_t      r_state;
    logic [15:0] r_hold_inst;
    logic [31:0] r_hold_pc;
    logic [15:0] r_out_inst;
    logic [15:0] r_out_imm;
    logic [31:0] r_out_pc;
    logic        r_out_valid;
    logic        r_out_two_word;

    // Next-state values.
    state_t      w_state_d;
    logic [15:0] w_hold_inst_d;
    logic [31:0] w_hold_pc_d;
    logic [15:0] w_out_inst_d;
    logic [15:0] w_out_imm_d;
    logic [31:0] w_out_pc_d;
    logic        w_out_valid_d;
    logic        w_out_two_word_d;

    // Next-state / output logic.
    always_comb begin
        // NOTE: every variable gets its hold value first, so any path that
        // does not assign it keeps the register and no latch is inferred.
        w_state_d        = r_state;
        w_hold_inst_d    = r_hold_inst;
        w_hold_pc_d      = r_hold_pc;
        w_out_inst_d     = r_out_inst;
        w_out_imm_d      = r_out_imm;
        w_out_pc_d       = r_out_pc;
        w_out_valid_d    = r_out_valid;
        w_out_two_word_d = r_out_two_word;

        if (bus.flush) begin
            // Flush beats stall; out_pc is deliberately left alone.
            w_state_d        = FIRST;
            w_hold_inst_d    = 16'h0000;
            w_out_inst_d     = NOP_WORD;
            w_out_imm_d      = 16'h0000;
            w_out_valid_d    = 1'b0;
            w_out_two_word_d = 1'b0;
        end else if (!bus.stall) begin
            unique case (r_state)
                FIRST: begin
                    if (bus.in_inst[IMM_BIT]) begin
                        // Park the opcode word and emit one bubble.
                        w_hold_inst_d    = bus.in_inst;
                        w_hold_pc_d      = bus.in_pc;
                        w_out_inst_d     = NOP_WORD;
                        w_out_imm_d      = 16'h0000;
                        w_out_valid_d    = 1'b0;
                        w_out_two_word_d = 1'b0;
                        w_state_d        = WAIT_IMM;
                    end else begin
                        w_out_inst_d     = bus.in_inst;
                        w_out_pc_d       = bus.in_pc;
                        w_out_imm_d      = 16'h0000;
                        w_out_valid_d    = 1'b1;
                        w_out_two_word_d = 1'b0;
                    end
                end
                WAIT_IMM: begin
                    // The incoming word is data, never an opcode, so its
                    // IMM_BIT is not looked at here.
                    w_out_inst_d     = r_hold_inst;
                    w_out_imm_d      = bus.in_inst;
                    w_out_pc_d       = r_hold_pc;
                    w_out_valid_d    = 1'b1;
                    w_out_two_word_d = 1'b1;
                    w_state_d        = FIRST;
                end
                default: w_state_d = FIRST;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values regardless of statement order.
        if (reset) begin
            r_state        <= FIRST;
            r_hold_inst    <= 16'h0000;
            r_hold_pc      <= 32'h0000_0000;
            r_out_inst     <= NOP_WORD;
            r_out_imm      <= 16'h0000;
            r_out_pc       <= 32'h0000_0000;
            r_out_valid    <= 1'b0;
            r_out_two_word <= 1'b0;
        end else begin
            r_state        <= w_state_d;
            r_hold_inst    <= w_hold_inst_d;
            r_hold_pc      <= w_hold_pc_d;
            r_out_inst     <= w_out_inst_d;
            r_out_imm      <= w_out_imm_d;
            r_out_pc       <= w_out_pc_d;
            r_out_valid    <= w_out_valid_d;
            r_out_two_word <= w_out_two_word_d;
        end
    end

    assign bus.out_inst     = r_out_inst;
    assign bus.out_imm      = r_out_imm;
    assign bus.out_pc       = r_out_pc;
    assign bus.out_valid    = r_out_valid;
    assign bus.out_two_word = r_out_two_word;
    assign bus.imm_wait     = (r_state == WAIT_IMM);

endmodule

// File: tb/tb_fetch_decode_buffer.sv
// -----------------------------------------------------------------------------
// tb_fetch_decode_buffer
// Directed bench for fetch_decode_buffer. Inputs change 1 ns after a rising
// edge; outputs are sampled 1 ns after the following rising edge. Each output
// snapshot is packed as
//   {out_valid, out_two_word, imm_wait, out_inst, out_imm, out_pc}
// and compared against a hand-computed vector.
// -----------------------------------------------------------------------------
module tb_fetch_decode_buffer;

    logic clk;
    logic reset;
    int   n_vec;
    int   n_bad;

    fetch_decode_buffer_if bus ();

    fetch_decode_buffer #(
        .IMM_BIT  (10),
        .NOP_WORD (16'h0000)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    wire [66:0] w_obs = {bus.out_valid, bus.out_two_word, bus.imm_wait,
                         bus.out_inst, bus.out_imm, bus.out_pc};

    logic [66:0] exp_v;

    // Apply one input set, clock once, then sample.
    task automatic drive(input logic rst, input logic stl, input logic fls,
                         input logic [15:0] inst, input logic [31:0] pc);
        reset       = rst;
        bus.stall   = stl;
        bus.flush   = fls;
        bus.in_inst = inst;
        bus.in_pc   = pc;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        drive(1'b1, 1'b0, 1'b0, 16'h0400, 32'd7);
        drive(1'b1, 1'b1, 1'b1, 16'hFFFF, 32'd9);
        exp_v = {1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 32'd0};
        n_vec++;
        if (w_obs !== exp_v) begin
            n_bad++;
            $display("FAIL reset: got %h want %h", w_obs, exp_v);
        end
    endtask

    task automatic test_one_word();
        logic [15:0] words [3] = '{16'h1234, 16'h2001, 16'h3003};
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 1'b0, words[i], 32'd33 + 32'(i));
            exp_v = {1'b1, 1'b0, 1'b0, words[i], 16'h0000, 32'd33 + 32'(i)};
            n_vec++;
            if (w_obs !== exp_v) begin
                n_bad++;
                $display("FAIL one_word[%0d]: got %h want %h", i, w_obs, exp_v);
            end
        end
    endtask

    task automatic test_two_word();
        drive(1'b0, 1'b0, 1'b0, 16'h0400, 32'd40);
        exp_v = {1'b0, 1'b0, 1'b1, 16'h0000, 16'h0000, 32'd35};
        n_vec++;
        if (w_obs !== exp_v) begin
            n_bad++;
            $display("FAIL two_word_bubble: got %h want %h", w_obs, exp_v);
        end
        drive(1'b0, 1'b0, 1'b0, 16'hBEEF, 32'd41);
        exp_v = {1'b1, 1'b1, 1'b0, 16'h0400, 16'hBEEF, 32'd40};
        n_vec++;
        if (w_obs !== exp_v) begin
            n_bad++;
            $display("FAIL two_word_packet: got %h want %h", w_obs, exp_v);
        end
    endtask

    task automatic test_imm_bit_set();
        drive(1'b0, 1'b0, 1'b0, 16'h0400, 32'd50);
        exp_v = {1'b0, 1'b0, 1'b1, 16'h0000, 16'h0000, 32'd40};
        n_vec++;
        if (w_obs !== exp_v) begin
            n_bad++;
            $display("FAIL immbit_bubble: got %h want %h", w_obs, exp_v);
        end
        drive(1'b0, 1'b0, 1'b0, 16'h0401, 32'd51);
        exp_v = {1'b1, 1'b1, 1'b0, 16'h0400, 16'h0401, 32'd50};
        n_vec++;
        if (w_obs !== exp_v) begin
            n_bad++;
            $display("FAIL immbit_packet: got %h want %h", w_obs, exp_v);
        end
        drive(1'b0, 1'b0, 1'b0, 16'h1111, 32'd52);
        exp_v = {1'b1, 1'b0, 1'b0, 16'h1111, 16'h0000, 32'd52};
        n_vec++;
        if (w_obs !== exp_v) begin
            n_bad++;
            $display("FAIL immbit_next: got %h want %h", w_obs, exp_v);
        end
    endtask

    task automatic test_stall();
        logic [15:0] junk [3] = '{16'hAAAA, 16'hBBBB, 16'hCCCC};
        drive(1'b0, 1'b0, 1'b0, 16'h0455, 32'd60);
        exp_v = {1'b0, 1'b0, 1'b1, 16'h0000, 16'h0000, 32'd52};
        n_vec++;
        if (w_obs !== exp_v) begin
            n_bad++;
            $display("FAIL stall_bubble: got %h want %h", w_obs, exp_v);
        end
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1, 1'b0, junk[i], 32'd61 + 32'(i));
            n_vec++;
            if (w_obs !== exp_v) begin
                n_bad++;
                $display("FAIL stall_hold[%0d]: got %h want %h", i, w_obs, exp_v);
            end
        end
        drive(1'b0, 1'b0, 1'b0, 16'hDDDD, 32'd64);
        exp_v = {1'b1, 1'b1, 1'b0, 16'h0455, 16'hDDDD, 32'd60};
        n_vec++;
        if (w_obs !== exp_v) begin
            n_bad++;
            $display("FAIL stall_release: got %h want %h", w_obs, exp_v);
        end
        // Stall in FIRST with a valid packet: packet must not change.
        drive(1'b0, 1'b1, 1'b0, 16'h2222, 32'd65);
        n_vec++;
        if (w_obs !== exp_v) begin
            n_bad++;
            $display("FAIL stall_first: got %h want %h", w_obs, exp_v);
        end
    endtask

    task automatic test_flush();
        for (int k = 0; k < 2; k++) begin
            // k=0: flush alone, k=1: flush together with stall.
            logic [31:0] base = (k == 0) ? 32'd70 : 32'd80;
            logic [31:0] prev = (k == 0) ? 32'd60 : 32'd72;
            drive(1'b0, 1'b0, 1'b0, 16'h0400, base);
            exp_v = {1'b0, 1'b0, 1'b1, 16'h0000, 16'h0000, prev};
            n_vec++;
            if (w_obs !== exp_v) begin
                n_bad++;
                $display("FAIL flush_bubble[%0d]: got %h want %h", k, w_obs, exp_v);
            end
            drive(1'b0, k[0], 1'b1, 16'h9999, base + 32'd1);
            exp_v = {1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, prev};
            n_vec++;
            if (w_obs !== exp_v) begin
                n_bad++;
                $display("FAIL flush_apply[%0d]: got %h want %h", k, w_obs, exp_v);
            end
            drive(1'b0, 1'b0, 1'b0, 16'h1111, base + 32'd2);
            exp_v = {1'b1, 1'b0, 1'b0, 16'h1111, 16'h0000, base + 32'd2};
            n_vec++;
            if (w_obs !== exp_v) begin
                n_bad++;
                $display("FAIL flush_next[%0d]: got %h want %h", k, w_obs, exp_v);
            end
        end
        // Flush from FIRST while a valid packet is shown.
        drive(1'b0, 1'b0, 1'b1, 16'h3333, 32'd90);
        exp_v = {1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 32'd82};
        n_vec++;
        if (w_obs !== exp_v) begin
            n_bad++;
            $display("FAIL flush_first: got %h want %h", w_obs, exp_v);
        end
    endtask

    task automatic test_reset_mid();
        drive(1'b0, 1'b0, 1'b0, 16'h0400, 32'd95);
        exp_v = {1'b0, 1'b0, 1'b1, 16'h0000, 16'h0000, 32'd82};
        n_vec++;
        if (w_obs !== exp_v) begin
            n_bad++;
            $display("FAIL rstmid_bubble: got %h want %h", w_obs, exp_v);
        end
        drive(1'b1, 1'b1, 1'b0, 16'h5A5A, 32'd96);
        exp_v = {1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 32'd0};
        n_vec++;
        if (w_obs !== exp_v) begin
            n_bad++;
            $display("FAIL rstmid_apply: got %h want %h", w_obs, exp_v);
        end
        drive(1'b0, 1'b0, 1'b0, 16'h2001, 32'd97);
        exp_v = {1'b1, 1'b0, 1'b0, 16'h2001, 16'h0000, 32'd97};
        n_vec++;
        if (w_obs !== exp_v) begin
            n_bad++;
            $display("FAIL rstmid_next: got %h want %h", w_obs, exp_v);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] ops  [2] = '{16'h0400, 16'h0600};
        logic [15:0] imms [2] = '{16'h1234, 16'h5555};
        logic [31:0] prev = 32'd97;
        for (int i = 0; i < 2; i++) begin
            logic [31:0] pc = 32'd100 + 32'(2 * i);
            drive(1'b0, 1'b0, 1'b0, ops[i], pc);
            exp_v = {1'b0, 1'b0, 1'b1, 16'h0000, 16'h0000, prev};
            n_vec++;
            if (w_obs !== exp_v) begin
                n_bad++;
                $display("FAIL b2b_bubble[%0d]: got %h want %h", i, w_obs, exp_v);
            end
            drive(1'b0, 1'b0, 1'b0, imms[i], pc + 32'd1);
            exp_v = {1'b1, 1'b1, 1'b0, ops[i], imms[i], pc};
            n_vec++;
            if (w_obs !== exp_v) begin
                n_bad++;
                $display("FAIL b2b_packet[%0d]: got %h want %h", i, w_obs, exp_v);
            end
            prev = pc;
        end
    endtask

    initial begin
        n_vec       = 0;
        n_bad       = 0;
        reset       = 1'b1;
        bus.stall   = 1'b0;
        bus.flush   = 1'b0;
        bus.in_inst = 16'h0000;
        bus.in_pc   = 32'd0;
        @(posedge clk);
        #1;
        test_reset();
        test_one_word();
        test_two_word();
        test_imm_bit_set();
        test_stall();
        test_flush();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/fetch_decode_buffer.md
Name: fetch_decode_buffer

Overview:
- Pipeline register between the Fetch stage and the Decode stage.
- Captures the 16-bit instruction word and propagated PC from Fetch on each rising clock edge. Fetch updates its PC on the falling edge, so inputs are stable at the rising edge.
- Assembles two-word instructions (opcode word followed by a 16-bit immediate word) into one Decode-visible packet.
- Inserts bubbles on flush and holds its contents on stall.

Parameters:
- IMM_BIT, 10, bit of the first instruction word that marks a two-word instruction; the immediate is the next fetched word.
- NOP_WORD, 16'h0000, encoding driven on out_inst whenever out_valid=0.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- stall  input  1  hold all state and outputs this cycle (same stall Fetch uses).
- flush  input  1  discard buffered and in-flight instruction (branch taken / interrupt).
- in_inst  input  16  instruction word from Fetch.
- in_pc  input  32  propagated PC from Fetch (PC+1 normally, PC during interrupt).
- out_inst  output  16  first (opcode) word to Decode.
- out_imm  output  16  immediate word; 0 for one-word instructions.
- out_pc  output  32  PC associated with out_inst, for call and interrupt return.
- out_valid  output  1  out_inst/out_imm/out_pc form a real instruction.
- out_two_word  output  1  packet carries a valid immediate.
- imm_wait  output  1  registered; 1 while the first word is held awaiting its immediate.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high, sampled on the rising edge of clk.
- Priority each rising edge: reset > flush > stall > normal operation.
- Reset:
  - state=FIRST; out_inst=NOP_WORD; out_imm=0; out_pc=0.
  - out_valid=0; out_two_word=0; imm_wait=0.
  - Internal hold_inst=0 and hold_pc=0.
- FSM states: FIRST, WAIT_IMM. imm_wait = (state==WAIT_IMM), registered.
- FIRST, no stall/flush:
  - If in_inst[IMM_BIT]==0: out_inst<=in_inst, out_pc<=in_pc, out_imm<=0, out_valid<=1, out_two_word<=0; stay FIRST.
  - If in_inst[IMM_BIT]==1: hold_inst<=in_inst, hold_pc<=in_pc; out_inst<=NOP_WORD, out_valid<=0, out_two_word<=0, out_imm<=0 (one bubble); out_pc unchanged; go WAIT_IMM.
- WAIT_IMM, no stall/flush:
  - out_inst<=hold_inst, out_imm<=in_inst, out_pc<=hold_pc, out_valid<=1, out_two_word<=1; go FIRST.
  - in_inst[IMM_BIT] is ignored in this state: the immediate word is never decoded as an opcode.
- Stall (no flush): state, hold registers and all outputs keep their values, in any state. A stall in WAIT_IMM keeps waiting; the immediate is taken on the first non-stalled edge.
- Flush, or flush with stall: state<=FIRST; hold_inst<=0; out_inst<=NOP_WORD; out_imm<=0; out_valid<=0; out_two_word<=0; out_pc unchanged. A pending first word in WAIT_IMM is discarded.
- Reset asserted mid-operation (either state): reset values on that edge, regardless of stall/flush.
- Latency:
  - One-word instruction: 1 cycle from input to out_valid.
  - Two-word instruction: visible on the edge after its immediate is sampled, i.e. 2 cycles after the first word; exactly one bubble cycle.
- Widths: all pass-through; no arithmetic. out_pc is never modified, only copied from in_pc or hold_pc.
- No combinational path from inputs to outputs.

Test Plan:
- Reset then three one-word words 16'h1234, 16'h2001, 16'h3003 (bit10=0), in_pc 33,34,35 -> out_inst 1234/2001/3003 one cycle later; out_pc 33/34/35; out_valid=1; out_imm=0.
- Word 16'h0400 (bit10=1) at pc 40, then 16'hBEEF at pc 41 -> cycle1: out_valid=0, imm_wait=1, out_inst=0000. Cycle2: out_inst=0400, out_imm=BEEF, out_pc=40, out_two_word=1, imm_wait=0.
- Immediate word with bit10 set: 16'h0400 then 16'h0401 -> 0401 treated as immediate; next word decoded normally in FIRST.
- Stall for 3 cycles while in WAIT_IMM with in_inst changing -> outputs frozen; the immediate is the word present on the first non-stalled edge.
- Flush (alone, and together with stall) in WAIT_IMM -> out_valid=0, out_inst=0000, state FIRST; following one-word 16'h1111 appears next cycle with out_valid=1.
- Reset asserted with stall=1 in WAIT_IMM -> all outputs at reset values on that edge; imm_wait=0.
